// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared geometry, address fields and FSM encoding for the L1 data cache controller
package dcache_pkg;

   localparam int TAG_W = 21;
   localparam int SETS  = 64;
   localparam int WORDS = 8;

   localparam int TAG_LSB = 11;
   localparam int IDX_LSB = 5;
   localparam int OFF_LSB = 2;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WB     = 2'd1;
   localparam logic [1:0] FILL   = 2'd2;
   localparam logic [1:0] REPLAY = 2'd3;

   // Word-aligned byte address of one beat within a line.
   function automatic logic [31:0] beat_addr(input logic [26:0] line, input logic [2:0] beat);
      return {line, beat, 2'b00};
   endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// rtl/dcache_tag_array.sv - per-set tag, valid and dirty storage with combinational read
module dcache_tag_array #(
   parameter int TAG_W = 21,
   parameter int SETS  = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk_i,
   input  logic             srst_ni,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             fill_we_i,
   input  logic [TAG_W-1:0] fill_tag_i,
   input  logic             dirty_set_i,
   input  logic             dirty_clr_i,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic             rd_valid_o,
   output logic             rd_dirty_o
);

   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  dirty_q;
   logic [TAG_W-1:0] tag_q [SETS];

   assign rd_tag_o   = tag_q[idx_i];
   assign rd_valid_o = valid_q[idx_i];
   assign rd_dirty_o = dirty_q[idx_i];

   // Valid/dirty bits: cleared by reset; a completed refill installs a clean line.
   always_ff @(posedge clk_i or negedge srst_ni) begin
      if (!srst_ni) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
         end
         if (dirty_set_i) dirty_q[idx_i] <= 1'b1;
         if (dirty_clr_i) dirty_q[idx_i] <= 1'b0;
      end
   end

   // Tags carry no reset; they are meaningless while the set is invalid.
   always_ff @(posedge clk_i) begin
      if (fill_we_i) tag_q[idx_i] <= fill_tag_i;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl #(
   parameter int TAG_W = 21,
   parameter int SETS  = 64,
   parameter int WORDS = 8
) (
   input  logic        clk,
   input  logic        srst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_wstrb,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   output logic [5:0]  ram_index,
   output logic [2:0]  ram_block_offset,
   output logic [3:0]  ram_wen,
   output logic        ram_ren,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   import dcache_pkg::*;

   localparam int IDX_W = $clog2(SETS);
   localparam int OFF_W = $clog2(WORDS);

   logic [1:0]       state_q, state_d;
   logic [OFF_W-1:0] beat_q, beat_d;

   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic [TAG_W-1:0] req_tag;
   logic [TAG_W-1:0] rd_tag;
   logic             rd_valid, rd_dirty;
   logic             hit, last_beat;
   logic             fill_we, dirty_set, dirty_clr;
   logic [1:0]       unused_byte_bits;

   assign idx              = cpu_addr[IDX_LSB +: IDX_W];
   assign off              = cpu_addr[OFF_LSB +: OFF_W];
   assign req_tag          = cpu_addr[TAG_LSB +: TAG_W];
   assign unused_byte_bits = cpu_addr[1:0];
   assign hit              = rd_valid && (rd_tag == req_tag);
   assign last_beat        = (beat_q == OFF_W'(WORDS - 1));

   dcache_tag_array #(
      .TAG_W (TAG_W),
      .SETS  (SETS),
      .IDX_W (IDX_W)
   ) u_tags (
      .clk_i       (clk),
      .srst_ni     (srst_n),
      .idx_i       (idx),
      .fill_we_i   (fill_we),
      .fill_tag_i  (req_tag),
      .dirty_set_i (dirty_set),
      .dirty_clr_i (dirty_clr),
      .rd_tag_o    (rd_tag),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty)
   );

   // Next state, beat counter and tag-array updates for hit / writeback / refill / replay.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      fill_we   = 1'b0;
      dirty_set = 1'b0;
      dirty_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (hit) begin
                  dirty_set = cpu_we;
               end else if (rd_valid && rd_dirty) begin
                  state_d = WB;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WB: begin
            if (mem_ready) begin
               if (last_beat) begin
                  beat_d    = '0;
                  dirty_clr = 1'b1;
                  state_d   = FILL;
               end else begin
                  beat_d = beat_q + OFF_W'(1);
               end
            end
         end
         FILL: begin
            if (mem_ready) begin
               if (last_beat) begin
                  beat_d  = '0;
                  fill_we = 1'b1;
                  state_d = REPLAY;
               end else begin
                  beat_d = beat_q + OFF_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode; reset forces every output low at once so an aborted burst cannot write the RAM.
   always_comb begin
      cpu_ready        = 1'b0;
      cpu_rdata        = '0;
      ram_index        = '0;
      ram_block_offset = '0;
      ram_wen          = '0;
      ram_ren          = 1'b0;
      ram_wdata        = '0;
      mem_valid        = 1'b0;
      mem_we           = 1'b0;
      mem_addr         = '0;
      mem_wdata        = '0;
      if (srst_n) begin
         case (state_q)
            IDLE: begin
               ram_index        = idx;
               ram_block_offset = off;
               if (cpu_req && hit) begin
                  cpu_ready = 1'b1;
                  if (cpu_we) begin
                     ram_wen   = cpu_wstrb;
                     ram_wdata = cpu_wdata;
                  end else begin
                     ram_ren   = 1'b1;
                     cpu_rdata = ram_rdata;
                  end
               end
            end
            WB: begin
               ram_index        = idx;
               ram_block_offset = beat_q;
               ram_ren          = 1'b1;
               mem_valid        = 1'b1;
               mem_we           = 1'b1;
               mem_addr         = beat_addr({rd_tag, idx}, beat_q);
               mem_wdata        = ram_rdata;
            end
            FILL: begin
               ram_index        = idx;
               ram_block_offset = beat_q;
               mem_valid        = 1'b1;
               mem_addr         = beat_addr(cpu_addr[31:5], beat_q);
               if (mem_ready) begin
                  ram_wen   = 4'hF;
                  ram_wdata = mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // State and beat counter registers.
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with RAM and memory models
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        srst_n;
   logic        cpu_req, cpu_we;
   logic [3:0]  cpu_wstrb;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic [5:0]  ram_index;
   logic [2:0]  ram_block_offset;
   logic [3:0]  ram_wen;
   logic        ram_ren;
   logic [31:0] ram_wdata, ram_rdata;
   logic        mem_valid, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_en;

   typedef struct packed {
      logic        we;
      logic [31:0] rdata;
   } cpu_exp_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_exp_t;

   cpu_exp_t  exp_cpu[$];
   beat_exp_t exp_beats[$];
   cpu_exp_t  mon_c;
   beat_exp_t mon_b;
   int        n_checks = 0;
   int        n_fail   = 0;
   logic [31:0] ram_mem [64][8];

   always #5 clk = ~clk;

   dcache_ctrl dut (
      .clk              (clk),
      .srst_n           (srst_n),
      .cpu_req          (cpu_req),
      .cpu_we           (cpu_we),
      .cpu_wstrb        (cpu_wstrb),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_ready        (cpu_ready),
      .cpu_rdata        (cpu_rdata),
      .ram_index        (ram_index),
      .ram_block_offset (ram_block_offset),
      .ram_wen          (ram_wen),
      .ram_ren          (ram_ren),
      .ram_wdata        (ram_wdata),
      .ram_rdata        (ram_rdata),
      .mem_valid        (mem_valid),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_ready        (mem_ready),
      .mem_rdata        (mem_rdata)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0044) return 32'h1122_3344;
      return {16'hC0DE, a[15:0]};
   endfunction

   assign ram_rdata = ram_mem[ram_index][ram_block_offset];
   assign mem_ready = mem_valid & mem_en;
   assign mem_rdata = mem_word(mem_addr);

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_wen[b]) ram_mem[ram_index][ram_block_offset][8*b +: 8] <= ram_wdata[8*b +: 8];
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_beats(input logic we, input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++)
         exp_beats.push_back('{we, base + 32'(4 * i), mem_word(base + 32'(4 * i))});
   endtask

   // Monitor: pops the scoreboard whenever the DUT completes a CPU access or a memory beat.
   always @(negedge clk) begin
      if (srst_n) begin
         if (cpu_ready) begin
            if (exp_cpu.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected cpu_ready at addr 0x%08h", cpu_addr);
            end else begin
               mon_c = exp_cpu.pop_front();
               check32("cpu_ready access type", {31'd0, cpu_we}, {31'd0, mon_c.we});
               if (!mon_c.we) check32("cpu_rdata", cpu_rdata, mon_c.rdata);
            end
         end
         if (mem_valid && mem_ready) begin
            if (exp_beats.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected mem beat at 0x%08h", mem_addr);
            end else begin
               mon_b = exp_beats.pop_front();
               check32("mem_we", {31'd0, mem_we}, {31'd0, mon_b.we});
               check32("mem_addr", mem_addr, mon_b.addr);
               if (mon_b.we) begin
                  check32("mem_wdata", mem_wdata, mon_b.wdata);
               end else begin
                  check32("fill ram_wen", {28'd0, ram_wen}, 32'hF);
                  check32("fill ram_offset", {29'd0, ram_block_offset}, {29'd0, mon_b.addr[4:2]});
                  check32("fill ram_wdata", ram_wdata, mon_b.wdata);
               end
            end
         end
      end
   end

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int exp_lat, input bit keep);
      int lat;
      bit done;
      exp_cpu.push_back('{we, rdata});
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wstrb = strb;
      cpu_wdata = wdata;
      lat  = 0;
      done = 1'b0;
      while (!done && lat <= 200) begin
         @(negedge clk);
         if (cpu_ready) done = 1'b1;
         else lat++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout waiting for cpu_ready addr 0x%08h", addr);
      end else begin
         check32("latency", 32'(lat), 32'(exp_lat));
         if (exp_lat == 0) begin
            check32("hit ram_offset", {29'd0, ram_block_offset}, {29'd0, addr[4:2]});
            check32("hit mem_valid", {31'd0, mem_valid}, 32'd0);
         end
      end
      @(posedge clk);
      #1;
      if (!keep) cpu_req = 1'b0;
   endtask

   task automatic wait_addr(input logic [31:0] a, output bit found);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (mem_valid && !mem_we && mem_addr == a) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout waiting for fill beat 0x%08h", a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      srst_n    = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_wstrb = 4'h0;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      mem_en    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check32("reset cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check32("reset mem_valid", {31'd0, mem_valid}, 32'd0);
      check32("reset ram_wen", {28'd0, ram_wen}, 32'd0);
      check32("reset ram_ren", {31'd0, ram_ren}, 32'd0);
      check32("reset mem_addr", mem_addr, 32'd0);
      srst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean miss on 0x40, refill word 0 returned after replay.
      push_beats(1'b0, 32'h40, 8);
      do_access(1'b0, 32'h40, 4'h0, 32'h0, 32'hC0DE_0040, 10, 1'b0);

      // Byte-merged store hit, then load hit of the merged word.
      do_access(1'b1, 32'h44, 4'b0011, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
      do_access(1'b0, 32'h44, 4'h0, 32'h0, 32'h1122_CCDD, 0, 1'b0);

      // Back-to-back load hits at word 0 and word 7.
      do_access(1'b0, 32'h40, 4'h0, 32'h0, 32'hC0DE_0040, 0, 1'b1);
      do_access(1'b0, 32'h5C, 4'h0, 32'h0, 32'hC0DE_005C, 0, 1'b0);

      // Dirty conflict miss: writeback of the old line, then refill with a 5-cycle stall on beat 3.
      exp_beats.push_back('{1'b1, 32'h40, 32'hC0DE_0040});
      exp_beats.push_back('{1'b1, 32'h44, 32'h1122_CCDD});
      for (int i = 2; i < 8; i++)
         exp_beats.push_back('{1'b1, 32'h40 + 32'(4 * i), 32'hC0DE_0040 + 32'(4 * i)});
      push_beats(1'b0, 32'h840, 8);
      fork
         do_access(1'b0, 32'h840, 4'h0, 32'h0, 32'hC0DE_0840, 23, 1'b0);
         begin
            wait_addr(32'h848, found);
            @(posedge clk);
            #1;
            mem_en = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check32("stall mem_addr", mem_addr, 32'h84C);
               check32("stall ram_wen", {28'd0, ram_wen}, 32'd0);
            end
            @(posedge clk);
            #1;
            mem_en = 1'b1;
         end
      join

      // Reset during refill beat 4, then the same load misses and refetches the whole line.
      push_beats(1'b0, 32'h1040, 5);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h1040;
      wait_addr(32'h1050, found);
      #1;
      srst_n = 1'b0;
      #1;
      check32("abort cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check32("abort mem_valid", {31'd0, mem_valid}, 32'd0);
      check32("abort ram_wen", {28'd0, ram_wen}, 32'd0);
      check32("abort ram_index", {26'd0, ram_index}, 32'd0);
      check32("abort mem_addr", mem_addr, 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      srst_n = 1'b1;
      check32("abort beats drained", 32'(exp_beats.size()), 32'd0);
      push_beats(1'b0, 32'h1040, 8);
      do_access(1'b0, 32'h1040, 4'h0, 32'h0, 32'hC0DE_1040, 10, 1'b0);

      repeat (3) @(posedge clk);
      check32("cpu scoreboard empty", 32'(exp_cpu.size()), 32'd0);
      check32("beat scoreboard empty", 32'(exp_beats.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
